sync_fifo_param: RTL and testbench

Parametrised single-clock synchronous FIFO that succeeds the fixed 8x16 FIFO.
- Data width, depth and almost-full/almost-empty thresholds are configurable; all DEPTH entries are usable.
- Supports a simultaneous read and write in one cycle, and a selectable first-word-fall-through (FWFT) output mode.
- Provides an occupancy count and sticky overflow/underflow error flags.
- Used as the generic buffering element between producer/consumer blocks and as the DUT for the functional-coverage environment.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 25 ++
 rtl/sync_fifo_param.sv | 94 +++++++++
 tb/tb_sync_fifo_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the parametrised synchronous FIFO
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_DEPTH = 16;

  typedef logic [clog2(DEF_DEPTH)-1:0] ptr_t;
  typedef logic [clog2(DEF_DEPTH):0]   cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register array with one synchronous write port and one asynchronous read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with optional first-word-fall-through output
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2,
  parameter int FWFT       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [DWIDTH-1:0]      din,
  input  logic                   clr_err,
  output logic [DWIDTH-1:0]      dout,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              wr_ok;
  logic              rd_ok;
  logic [DWIDTH-1:0] mem_rdata;

  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign almost_empty = (cnt <= CW'(AEMPTY_THR));
  assign almost_full  = (cnt >= CW'(AFULL_THR));
  assign count        = cnt;

  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow  <= (wr & full & ~rd) | (overflow & ~clr_err);
      underflow <= (rd & empty) | (underflow & ~clr_err);
    end
  end

  fifo_mem #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok & ~rst),
    .waddr(wptr),
    .wdata(din),
    .raddr(rptr),
    .rdata(mem_rdata)
  );

  generate
    if (FWFT == int'(MODE_FWFT)) begin : g_fwft
      // Head entry is shown directly; forced to zero while empty so reset leaves dout clean
      assign dout = empty ? '0 : mem_rdata;
    end else begin : g_std
      logic [DWIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (rst)        dout_q <= '0;
        else if (rd_ok) dout_q <= mem_rdata;
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench driving a standard and an FWFT FIFO with identical stimulus
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] s_dout, f_dout;
  logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AFULL_THR(14), .AEMPTY_THR(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .clr_err(clr_err),
    .dout(s_dout), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
    .almost_full(s_af), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AFULL_THR(14), .AEMPTY_THR(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .clr_err(clr_err),
    .dout(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_ae),
    .almost_full(f_af), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_std[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic status();
    int n;
    n = mdl.size();
    chk("s_count", 32'(s_count), n);
    chk("f_count", 32'(f_count), n);
    chk("s_empty", 32'(s_empty), 32'(n == 0));
    chk("s_full",  32'(s_full),  32'(n == 16));
    chk("s_aempty", 32'(s_ae),   32'(n <= 2));
    chk("s_afull",  32'(s_af),   32'(n >= 14));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("s_udf",   32'(s_udf),   32'(m_udf));
    chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
  endtask

  task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c = 1'b0);
    int  n;
    bit  m_full, m_empty, wok, rok;
    n       = mdl.size();
    m_full  = (n == 16);
    m_empty = (n == 0);
    wok     = w && (!m_full || r);
    rok     = r && !m_empty;
    wr = w; rd = r; din = d; clr_err = c;
    @(posedge clk);
    if (rok) exp_std.push_back(mdl.pop_front());
    if (wok) mdl.push_back(d);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && m_full && !r) m_ovf = 1'b1;
    if (r && m_empty) m_udf = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    mdl.delete();
    exp_std.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: a standard read shows data one cycle later; FWFT always shows the head
  always @(negedge clk) begin
    if (!rst && exp_std.size() > 0) begin
      logic [7:0] e;
      e = exp_std.pop_front();
      chk("std_dout", 32'(s_dout), 32'(e));
    end
    if (!rst && mdl.size() > 0) chk("fwft_dout", 32'(f_dout), 32'(mdl[0]));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_dout", 32'(s_dout), 32'h0);
    chk("reset_ae", 32'(s_ae), 32'h1);
    status();

    // 1: fill to full, then overflow
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 13) chk("afull_at_13", 32'(s_af), 32'h0);
      if (i == 14) chk("afull_at_14", 32'(s_af), 32'h1);
    end
    chk("full_16", 32'(s_full), 32'h1);
    chk("count_16", 32'(s_count), 32'd16);
    cyc(1'b1, 1'b0, 8'h99);
    chk("ovf_17th", 32'(s_ovf), 32'h1);
    chk("count_stays_16", 32'(s_count), 32'd16);
    status();

    // 2: drain, then underflow with dout held
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("empty_after_drain", 32'(s_empty), 32'h1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_set", 32'(s_udf), 32'h1);
    chk("dout_held", 32'(s_dout), 32'h10);
    status();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", 32'(s_ovf), 32'h0);
    chk("clr_udf", 32'(s_udf), 32'h0);

    // 3: hold at 8 with simultaneous read/write across wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h09 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 8'(8'hA0 + i));
      chk("count_8", 32'(s_count), 32'd8);
    end
    status();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("last_of_stream", 32'(s_dout), 32'hB3);

    // 4: full plus wr&rd
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b1, 8'h55);
    chk("full_rw_count", 32'(s_count), 32'd16);
    chk("full_rw_no_ovf", 32'(s_ovf), 32'h0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("x55_last", 32'(s_dout), 32'h55);
    status();

    // 5: empty plus wr&rd
    cyc(1'b1, 1'b1, 8'h3C);
    chk("empty_rw_count", 32'(s_count), 32'd1);
    chk("empty_rw_udf", 32'(s_udf), 32'h1);
    chk("fwft_3c", 32'(f_dout), 32'h3C);
    chk("fwft_not_empty", 32'(f_empty), 32'h0);
    cyc(1'b0, 1'b1, 8'h00);
    status();

    // 6: reset mid-operation
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    chk("count_10", 32'(s_count), 32'd10);
    do_reset();
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'h1);
    chk("rst_dout", 32'(s_dout), 32'h0);
    chk("rst_ovf", 32'(s_ovf), 32'h0);
    chk("rst_udf", 32'(s_udf), 32'h0);
    status();
    cyc(1'b1, 1'b0, 8'h77);
    chk("fwft_77", 32'(f_dout), 32'h77);
    cyc(1'b0, 1'b1, 8'h00);
    chk("std_77", 32'(s_dout), 32'h77);
    status();

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
